// File: rtl/countdown_sequencer.sv
// mm:ss countdown sequencer for the VGA text painter: 1 s prescaler,
// IDLE/RUN/PAUSE/DONE control and BCD digit registers.
module countdown_sequencer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int DONE_HOLD_SEC = 5
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [3:0] preset_mD,
    input  logic [3:0] preset_mU,
    input  logic [3:0] preset_sD,
    input  logic [3:0] preset_sU,
    output logic [3:0] mDecimal,
    output logic [3:0] mUnit,
    output logic [3:0] sDecimal,
    output logic [3:0] sUnit,
    output logic [2:0] actualState,
    output logic       finish,
    output logic       sec_tick
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (DONE_HOLD_SEC > 1) ? $clog2(DONE_HOLD_SEC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     digits;
    logic [15:0]     digits_nxt;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nxt;
    logic [HW-1:0]   hold;
    logic [HW-1:0]   hold_nxt;
    logic            finish_nxt;
    logic            tick_nxt;

    logic [15:0]     preset_sat;
    logic            preset_zero;
    logic            presc_wrap;
    logic            restart;
    logic [15:0]     digits_dec;

    // Clamp one BCD digit to its legal maximum.
    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction

    // One-second decrement of {mD, mU, sD, sU} with the sexagesimal borrow chain.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [3:0] md;
        logic [3:0] mu;
        logic [3:0] sd;
        logic [3:0] su;
        {md, mu, sd, su} = d;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (sd != 4'd0) begin
                sd = sd - 4'd1;
            end else begin
                sd = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    md = (md != 4'd0) ? md - 4'd1 : 4'd0;
                end
            end
        end
        return {md, mu, sd, su};
    endfunction

    assign preset_sat  = {sat_digit(preset_mD, 4'd9), sat_digit(preset_mU, 4'd9),
                          sat_digit(preset_sD, 4'd5), sat_digit(preset_sU, 4'd9)};
    assign preset_zero = (preset_sat == 16'h0000);
    assign presc_wrap  = (presc == PW'(TICKS_PER_SEC - 1));
    assign restart     = start && !preset_zero;
    assign digits_dec  = bcd_dec(digits);

    always_comb begin
        state_nxt  = state;
        digits_nxt = digits;
        presc_nxt  = presc;
        hold_nxt   = hold;
        tick_nxt   = 1'b0;

        if (clear) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            hold_nxt  = '0;
            if (state == IDLE) begin
                digits_nxt = preset_sat;
            end
        end else begin
            case (state)
                IDLE: begin
                    digits_nxt = preset_sat;
                    presc_nxt  = '0;
                    hold_nxt   = '0;
                    if (restart) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (restart) begin
                        digits_nxt = preset_sat;
                        presc_nxt  = '0;
                    end else begin
                        // The cycle that carries the pause pulse is still a RUN cycle and counts.
                        presc_nxt = presc_wrap ? '0 : presc + PW'(1);
                        if (presc_wrap) begin
                            digits_nxt = digits_dec;
                            tick_nxt   = 1'b1;
                            if (digits_dec == 16'h0000) begin
                                state_nxt = DONE;
                                hold_nxt  = '0;
                            end
                        end
                        if (pause && state_nxt == RUN) begin
                            state_nxt = PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (restart) begin
                        state_nxt  = RUN;
                        digits_nxt = preset_sat;
                        presc_nxt  = '0;
                    end else if (pause) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    digits_nxt = 16'h0000;
                    presc_nxt  = presc_wrap ? '0 : presc + PW'(1);
                    if (presc_wrap) begin
                        if (hold == HW'(DONE_HOLD_SEC - 1)) begin
                            state_nxt = IDLE;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold + HW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    hold_nxt  = '0;
                end
            endcase
        end

        finish_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state    <= IDLE;
            digits   <= 16'h0000;
            presc    <= '0;
            hold     <= '0;
            finish   <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            state    <= state_nxt;
            digits   <= digits_nxt;
            presc    <= presc_nxt;
            hold     <= hold_nxt;
            finish   <= finish_nxt;
            sec_tick <= tick_nxt;
        end
    end

    assign {mDecimal, mUnit, sDecimal, sUnit} = digits;
    assign actualState = state;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICKS_PER_SEC=4, DONE_HOLD_SEC=2.
module tb_countdown_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic       clear;
    logic [3:0] preset_mD;
    logic [3:0] preset_mU;
    logic [3:0] preset_sD;
    logic [3:0] preset_sU;
    logic [3:0] mDecimal;
    logic [3:0] mUnit;
    logic [3:0] sDecimal;
    logic [3:0] sUnit;
    logic [2:0] actualState;
    logic       finish;
    logic       sec_tick;

    int checks   = 0;
    int failures = 0;

    countdown_sequencer #(
        .TICKS_PER_SEC(4),
        .DONE_HOLD_SEC(2)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .preset_mD  (preset_mD),
        .preset_mU  (preset_mU),
        .preset_sD  (preset_sD),
        .preset_sU  (preset_sU),
        .mDecimal   (mDecimal),
        .mUnit      (mUnit),
        .sDecimal   (sDecimal),
        .sUnit      (sUnit),
        .actualState(actualState),
        .finish     (finish),
        .sec_tick   (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input logic [15:0] exp);
        chk(tag, {16'h0, mDecimal, mUnit, sDecimal, sUnit}, {16'h0, exp});
    endtask

    task automatic set_preset(input logic [15:0] p);
        {preset_mD, preset_mU, preset_sD, preset_sU} = p;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        set_preset(16'h0000);
        cyc(2);
        chk("rst_state", 32'(actualState), 32'd0);
        chk_digits("rst_digits", 16'h0000);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_tick", 32'(sec_tick), 32'd0);

        // P=00:03 countdown to DONE
        reset = 1'b1;
        set_preset(16'h0003);
        cyc(1);
        chk_digits("idle_follow", 16'h0003);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("run_enter", 32'(actualState), 32'd1);
        chk_digits("run_load", 16'h0003);
        cyc(3);
        chk_digits("run_hold3", 16'h0003);
        cyc(1);
        chk_digits("run_0002", 16'h0002);
        chk("tick_0002", 32'(sec_tick), 32'd1);
        cyc(1);
        chk("tick_low", 32'(sec_tick), 32'd0);
        cyc(3);
        chk_digits("run_0001", 16'h0001);
        cyc(3);
        chk("pre_done_state", 32'(actualState), 32'd1);
        cyc(1);
        chk_digits("run_0000", 16'h0000);
        chk("done_state", 32'(actualState), 32'd3);
        chk("done_finish", 32'(finish), 32'd1);

        // DONE hold: finish for 8 cycles, start ignored
        start = 1'b1; cyc(1); start = 1'b0;
        chk("done_start_ign", 32'(actualState), 32'd3);
        cyc(6);
        chk("done_finish_d7", 32'(finish), 32'd1);
        chk_digits("done_digits", 16'h0000);
        cyc(1);
        chk("done_exit_state", 32'(actualState), 32'd0);
        chk("done_exit_finish", 32'(finish), 32'd0);
        cyc(1);
        chk_digits("done_exit_p", 16'h0003);

        // P=10:00, one second -> 09:59
        set_preset(16'h1000);
        start = 1'b1; cyc(1); start = 1'b0;
        chk_digits("p1000_load", 16'h1000);
        cyc(3);
        chk("p1000_tick0", 32'(sec_tick), 32'd0);
        cyc(1);
        chk_digits("p1000_0959", 16'h0959);
        chk("p1000_tick1", 32'(sec_tick), 32'd1);
        cyc(1);
        chk("p1000_tick_end", 32'(sec_tick), 32'd0);
        chk_digits("p1000_hold", 16'h0959);

        // P=00:05 restart, pause, resume with prescaler preserved
        set_preset(16'h0005);
        start = 1'b1; cyc(1); start = 1'b0;
        chk_digits("p0005_load", 16'h0005);
        cyc(4);
        chk_digits("p0005_0004", 16'h0004);
        cyc(1);
        pause = 1'b1; cyc(1); pause = 1'b0;
        chk("pause_state", 32'(actualState), 32'd2);
        cyc(20);
        chk_digits("pause_frozen", 16'h0004);
        chk("pause_still", 32'(actualState), 32'd2);
        chk("pause_tick", 32'(sec_tick), 32'd0);
        pause = 1'b1; cyc(1); pause = 1'b0;
        chk("resume_state", 32'(actualState), 32'd1);
        cyc(1);
        chk_digits("resume_r1", 16'h0004);
        cyc(1);
        chk_digits("resume_r2", 16'h0003);
        chk("resume_tick", 32'(sec_tick), 32'd1);

        // clear from RUN
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clear_state", 32'(actualState), 32'd0);
        chk("clear_finish", 32'(finish), 32'd0);
        cyc(1);
        chk_digits("clear_digits_p", 16'h0005);

        // P=00:00 start ignored; pause in IDLE ignored
        set_preset(16'h0000);
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("zero_start_ign", 32'(actualState), 32'd0);
        chk_digits("zero_digits", 16'h0000);
        pause = 1'b1; cyc(1); pause = 1'b0;
        chk("idle_pause_ign", 32'(actualState), 32'd0);

        // invalid preset sanitised
        set_preset(16'h7F9A);
        cyc(1);
        chk_digits("sanitise", 16'h7959);

        // clear beats start while running at 00:07
        set_preset(16'h0007);
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("p0007_run", 32'(actualState), 32'd1);
        clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
        chk("clear_over_start", 32'(actualState), 32'd0);
        cyc(1);
        chk_digits("clear_over_p", 16'h0007);

        // reset on the wrap cycle overrides the decrement
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        reset = 1'b0; cyc(1);
        chk("midrst_state", 32'(actualState), 32'd0);
        chk_digits("midrst_digits", 16'h0000);
        chk("midrst_tick", 32'(sec_tick), 32'd0);
        chk("midrst_finish", 32'(finish), 32'd0);
        reset = 1'b1;
        cyc(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Sequences the mm:ss countdown shown by the VGA text painter.
- Drives the four BCD digit inputs, the 3-bit state code and the finish flag consumed by the VGA painter top level.
- Owns the 1 s prescaler and the IDLE/RUN/PAUSE/DONE state machine.
- Runs in the clk_100MHz domain. Inputs are pre-debounced single-cycle command pulses.

Parameters:
TICKS_PER_SEC, 100_000_000, clk_100MHz cycles per countdown second (sim: 4)
DONE_HOLD_SEC, 5, seconds spent in DONE before automatic return to IDLE (>=1)

Ports:
clk_100MHz  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  1-cycle pulse: begin or restart countdown from preset
pause  input  1  1-cycle pulse: toggle RUN<->PAUSE
clear  input  1  1-cycle pulse: abort to IDLE
preset_mD  input  4  preset minutes tens, BCD
preset_mU  input  4  preset minutes units, BCD
preset_sD  input  4  preset seconds tens, BCD
preset_sU  input  4  preset seconds units, BCD
mDecimal  output  4  displayed minutes tens
mUnit  output  4  displayed minutes units
sDecimal  output  4  displayed seconds tens
sUnit  output  4  displayed seconds units
actualState  output  3  0=IDLE 1=RUN 2=PAUSE 3=DONE
finish  output  1  high while in DONE
sec_tick  output  1  1-cycle pulse on each counted second (RUN only)

Behaviour:
- All outputs registered. Reset (reset==0 at a clk edge):
  - state=IDLE, digits=0, finish=0, sec_tick=0, prescaler=0, hold counter=0.
- Preset sanitising:
  - preset_mD, preset_mU or preset_sU >9 is treated as 9.
  - preset_sD >5 is treated as 5.
  - The sanitised preset is "P".
- Command priority when pulses coincide: clear > start > pause.
- IDLE:
  - Digits follow P with 1-cycle latency.
  - start with P!=00:00: next cycle RUN, digits=P, prescaler=0.
  - start with P==00:00: ignored.
  - pause: ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1. On the wrap cycle, sec_tick=1 next cycle and digits decrement by 1 s.
  - Borrow chain:
    - sU 0->9 borrows from sD.
    - sD 0->5 borrows from mU.
    - mU 0->9 borrows from mD.
    - mD decrements.
  - If the decrement yields 00:00: state=DONE and finish=1 in the same registered update as the digits.
  - pause: state=PAUSE; prescaler and digits frozen.
  - start: restart from P, prescaler=0.
- PAUSE:
  - pause: state=RUN; prescaler resumes from its held value, no lost or extra counts.
  - start: RUN from P.
  - sec_tick stays 0.
- DONE:
  - Digits hold 00:00.
  - Prescaler free-runs and counts DONE_HOLD_SEC seconds; on completion the next cycle is IDLE with finish=0.
  - start and pause: ignored.
- clear, any state: next cycle IDLE, finish=0, prescaler=0. Digits show P on the following cycle.
- Illegal state codes 4-7: next cycle IDLE.
- reset low mid-count overrides everything on that edge.
- Digits never leave the BCD/sexagesimal range. The preset range is 00:00-99:59.

Test Plan:
- TICKS_PER_SEC=4, P=00:03, start -> RUN. Digits 00:02, 00:01, 00:00 at 4-cycle spacing. actualState=3 and finish=1 on the same cycle digits reach 00:00.
- P=10:00, start, one second elapsed -> digits 09:59; sec_tick high exactly 1 cycle.
- P=00:05, start, pause after 6 cycles, hold 20 cycles, pause -> digits unchanged during PAUSE. 00:04->00:03 transition 2 cycles after resume (prescaler preserved).
- DONE reached with DONE_HOLD_SEC=2, TICKS_PER_SEC=4 -> finish high 8 cycles, then actualState=0 with digits = P.
- P=00:00, start -> remains IDLE. P=7:F:9:A (invalid) -> digits display 79:59.
- RUN at 00:07: clear and start asserted on the same cycle -> IDLE. reset=0 mid-RUN -> all outputs 0 next cycle.
